// File: rtl/fp_cmp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fp_cmp_pkg
// Description : Shared definitions for the floating-point compare pipeline:
//               op encodings and the signed compare built on magnitude flags.
// Revision    : 1.0 - initial release
// ============================================================================
package fp_cmp_pkg;

    typedef enum logic [1:0] {
        OP_GT = 2'b00,
        OP_LT = 2'b01,
        OP_EQ = 2'b10,
        OP_GE = 2'b11
    } op_e;

    typedef struct packed {
        logic gt;
        logic eq;
    } cmp_t;

    // Signed ordering from sign bits plus unsigned magnitude flags. Works for
    // any field width because the magnitude compare is done by the caller.
    function automatic cmp_t fp_signed_cmp(
        input logic a_sign,
        input logic b_sign,
        input logic mag_gt,
        input logic mag_eq,
        input logic a_zero,
        input logic b_zero
    );
        cmp_t r;
        r.eq = (a_zero && b_zero) || ((a_sign == b_sign) && mag_eq);
        if (a_zero && b_zero) begin
            r.gt = 1'b0;                    // +0 and -0 are equal
        end else if (a_sign != b_sign) begin
            r.gt = !a_sign;                 // positive operand wins
        end else if (!a_sign) begin
            r.gt = mag_gt;
        end else begin
            r.gt = !mag_gt && !mag_eq;      // both negative: smaller magnitude wins
        end
        return r;
    endfunction

    // Select the requested relation of a to b.
    function automatic logic op_result(input op_e op, input cmp_t c);
        logic r;
        case (op)
            OP_GT:   r = c.gt;
            OP_LT:   r = !c.gt && !c.eq;
            OP_EQ:   r = c.eq;
            OP_GE:   r = c.gt || c.eq;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp_mag_cmp.sv
`default_nettype none
// ============================================================================
// Module      : fp_mag_cmp
// Description : Unsigned magnitude compare of packed {exp,frac} fields.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_mag_cmp #(
    parameter int W = 12
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         gt,
    output logic         eq
);

    assign gt = (a > b);
    assign eq = (a == b);

endmodule
`default_nettype wire

// File: rtl/fp_cmp_pipe.sv
`default_nettype none
// ============================================================================
// Module      : fp_cmp_pipe
// Description : Two-stage sign/magnitude compare pipeline with valid/ready
//               handshakes and a running maximum of delivered results.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_cmp_pipe
    import fp_cmp_pkg::*;
#(
    parameter int EXP_W  = 4,
    parameter int FRAC_W = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      a_sign,
    input  logic [EXP_W-1:0]          a_exp,
    input  logic [FRAC_W-1:0]         a_frac,
    input  logic                      b_sign,
    input  logic [EXP_W-1:0]          b_exp,
    input  logic [FRAC_W-1:0]         b_frac,
    input  logic [1:0]                op,
    input  logic                      acc_clr,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_res,
    output logic [EXP_W+FRAC_W:0]     out_max,
    output logic [EXP_W+FRAC_W:0]     acc_max,
    output logic                      acc_vld
);

    localparam int MAG_W = EXP_W + FRAC_W;
    localparam int VAL_W = 1 + MAG_W;

    // Stage 1 state
    logic             s1_valid;
    logic [VAL_W-1:0] s1_a;
    logic [VAL_W-1:0] s1_b;
    op_e              s1_op;
    logic             s1_clr;
    logic             s1_mag_gt;
    logic             s1_mag_eq;

    // Stage 2 state (out_res / out_max are the registers themselves)
    logic             s2_valid;
    logic             s2_clr;

    logic             ld1;
    logic             ld2;
    logic             in_mag_gt;
    logic             in_mag_eq;
    logic             acc_mag_gt;
    logic             acc_mag_eq;
    cmp_t             st2_cmp;
    cmp_t             acc_cmp;
    logic             st2_res;
    logic [VAL_W-1:0] st2_max;
    logic             out_hs;

    // Each stage advances when it is empty or its successor is advancing.
    assign ld2       = !s2_valid || out_ready;
    assign ld1       = !s1_valid || ld2;
    assign in_ready  = ld1;
    assign out_valid = s2_valid;
    assign out_hs    = s2_valid && out_ready;

    fp_mag_cmp #(.W(MAG_W)) u_in_cmp (
        .a  ({a_exp, a_frac}),
        .b  ({b_exp, b_frac}),
        .gt (in_mag_gt),
        .eq (in_mag_eq)
    );

    // Accumulator compares the result leaving stage 2 against the held max.
    fp_mag_cmp #(.W(MAG_W)) u_acc_cmp (
        .a  (out_max[MAG_W-1:0]),
        .b  (acc_max[MAG_W-1:0]),
        .gt (acc_mag_gt),
        .eq (acc_mag_eq)
    );

    // Signed decisions for stage 2 and for the accumulator update.
    always_comb begin
        st2_cmp = fp_signed_cmp(s1_a[MAG_W], s1_b[MAG_W], s1_mag_gt, s1_mag_eq,
                                (s1_a[MAG_W-1:0] == '0), (s1_b[MAG_W-1:0] == '0));
        st2_res = op_result(s1_op, st2_cmp);
        st2_max = (st2_cmp.gt || st2_cmp.eq) ? s1_a : s1_b;
        acc_cmp = fp_signed_cmp(out_max[MAG_W], acc_max[MAG_W], acc_mag_gt, acc_mag_eq,
                                (out_max[MAG_W-1:0] == '0), (acc_max[MAG_W-1:0] == '0));
    end

    // Stage 1: capture operands, op, clear flag and magnitude flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_op     <= OP_GT;
            s1_clr    <= 1'b0;
            s1_mag_gt <= 1'b0;
            s1_mag_eq <= 1'b0;
        end else if (ld1) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a      <= {a_sign, a_exp, a_frac};
                s1_b      <= {b_sign, b_exp, b_frac};
                s1_op     <= op_e'(op);
                s1_clr    <= acc_clr;
                s1_mag_gt <= in_mag_gt;
                s1_mag_eq <= in_mag_eq;
            end
        end
    end

    // Stage 2: register the compare result and the larger operand.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            out_res  <= 1'b0;
            out_max  <= '0;
            s2_clr   <= 1'b0;
        end else if (ld2) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_res <= st2_res;
                out_max <= st2_max;
                s2_clr  <= s1_clr;
            end
        end
    end

    // Running maximum: reload on clear or first result, else keep the larger;
    // a tie leaves the held value (and its zero sign) untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_max <= '0;
            acc_vld <= 1'b0;
        end else if (out_hs) begin
            acc_vld <= 1'b1;
            if (s2_clr || !acc_vld || acc_cmp.gt) begin
                acc_max <= out_max;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp_cmp_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_cmp_pipe
// Description : Directed self-checking bench for fp_cmp_pipe (EXP_W=4,
//               FRAC_W=8) with an in-order expected-result queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_cmp_pipe;

    localparam int EXP_W  = 4;
    localparam int FRAC_W = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        a_sign, b_sign;
    logic [3:0]  a_exp, b_exp;
    logic [7:0]  a_frac, b_frac;
    logic [1:0]  op;
    logic        acc_clr;
    logic        out_valid;
    logic        out_ready;
    logic        out_res;
    logic [12:0] out_max;
    logic [12:0] acc_max;
    logic        acc_vld;

    int          n_vec = 0;
    int          n_err = 0;
    int          n_out = 0;
    int          n_acc = 0;
    logic [13:0] expq[$];          // {res, max}, in input order
    logic        stall = 1'b0;
    logic        h_res;
    logic [12:0] h_max;

    localparam logic [1:0] GT = 2'b00, LT = 2'b01, EQ = 2'b10, GE = 2'b11;

    fp_cmp_pipe #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_sign    (a_sign),
        .a_exp     (a_exp),
        .a_frac    (a_frac),
        .b_sign    (b_sign),
        .b_exp     (b_exp),
        .b_frac    (b_frac),
        .op        (op),
        .acc_clr   (acc_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_max   (out_max),
        .acc_max   (acc_max),
        .acc_vld   (acc_vld)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one pair from posedge+1 and hold it until the handshake edge.
    task automatic send(input logic [12:0] a, input logic [12:0] b, input logic [1:0] o,
                        input logic clr, input logic eres, input logic [12:0] emax);
        bit hs;
        int n;
        a_sign = a[12]; a_exp = a[11:8]; a_frac = a[7:0];
        b_sign = b[12]; b_exp = b[11:8]; b_frac = b[7:0];
        op = o; acc_clr = clr; in_valid = 1'b1;
        expq.push_back({eres, emax});
        hs = 1'b0;
        n  = 0;
        while (!hs && n < 50) begin
            @(negedge clk);
            hs = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!hs) chk("send_timeout", 32'(n), 0);
        else n_acc++;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (expq.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (expq.size() != 0) chk("drain_timeout", expq.size(), 0);
    endtask

    // Output monitor: score each handshake in order and hold-stability while stalled.
    always @(negedge clk) begin
        logic [13:0] e;
        if (rst_n && out_valid && out_ready) begin
            if (expq.size() == 0) begin
                chk("extra_out", expq.size(), 1);
            end else begin
                e = expq.pop_front();
                chk($sformatf("res#%0d", n_out), out_res, e[13]);
                chk($sformatf("max#%0d", n_out), out_max, e[12:0]);
                n_out++;
            end
        end
        if (rst_n && stall) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_res", out_res, h_res);
            chk("stall_max", out_max, h_max);
        end
        stall = rst_n && out_valid && !out_ready;
        h_res = out_res;
        h_max = out_max;
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; acc_clr = 1'b0; op = GT;
        a_sign = 0; a_exp = 0; a_frac = 0; b_sign = 0; b_exp = 0; b_frac = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_res", out_res, 0);
        chk("rst_out_max", out_max, 0);
        chk("rst_acc_max", acc_max, 0);
        chk("rst_acc_vld", acc_vld, 0);
        rst_n = 1'b1;
        chk("rst_in_ready", in_ready, 1);

        // +e1 f100 vs +e0 f100, two-cycle latency
        send(13'h0164, 13'h0064, GT, 1'b0, 1'b1, 13'h0164);
        chk("lat_c1_valid", out_valid, 0);
        @(posedge clk); #1;
        chk("lat_c2_valid", out_valid, 1);
        drain();
        chk("first_acc_max", acc_max, 13'h0164);
        chk("first_acc_vld", acc_vld, 1);

        // signed zero and negative cases
        send(13'h0000, 13'h1000, EQ, 1'b0, 1'b1, 13'h0000);
        send(13'h0000, 13'h1000, GT, 1'b0, 1'b0, 13'h0000);
        send(13'h0000, 13'h1000, GE, 1'b0, 1'b1, 13'h0000);
        send(13'h0000, 13'h1000, LT, 1'b0, 1'b0, 13'h0000);
        send(13'h1164, 13'h1264, GT, 1'b0, 1'b1, 13'h1164);
        send(13'h1164, 13'h1264, LT, 1'b0, 1'b0, 13'h1164);
        send(13'h0100, 13'h1100, GT, 1'b0, 1'b1, 13'h0100);
        send(13'h1000, 13'h0005, GE, 1'b0, 1'b0, 13'h0005);
        send(13'h0305, 13'h0305, EQ, 1'b0, 1'b1, 13'h0305);
        send(13'h1207, 13'h1207, LT, 1'b0, 1'b0, 13'h1207);
        send(13'h0000, 13'h1100, LT, 1'b0, 1'b0, 13'h0000);
        drain();

        // five back-to-back pairs against a 4-cycle output stall
        out_ready = 1'b0;
        n_acc = 0;
        fork
            begin
                send(13'h0201, 13'h0202, GT, 1'b0, 1'b0, 13'h0202);
                send(13'h1300, 13'h0001, LT, 1'b0, 1'b1, 13'h0001);
                send(13'h0409, 13'h0409, GE, 1'b0, 1'b1, 13'h0409);
                send(13'h1101, 13'h1102, GT, 1'b0, 1'b1, 13'h1101);
                send(13'h0000, 13'h1001, EQ, 1'b0, 1'b0, 13'h0000);
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                chk("stall_in_ready", in_ready, 0);
                chk("stall_accepted", 32'(n_acc), 2);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        chk("stream_count", 32'(n_out), 17);

        // running maximum with clears and a signed-zero tie
        send(13'h0100, 13'h0100, EQ, 1'b1, 1'b1, 13'h0100);
        drain();
        chk("acc_e1", acc_max, 13'h0100);
        send(13'h0300, 13'h0300, EQ, 1'b0, 1'b1, 13'h0300);
        drain();
        chk("acc_e3", acc_max, 13'h0300);
        send(13'h1500, 13'h1500, EQ, 1'b0, 1'b1, 13'h1500);
        drain();
        chk("acc_neg_e5", acc_max, 13'h0300);
        send(13'h0200, 13'h0200, EQ, 1'b1, 1'b1, 13'h0200);
        drain();
        chk("acc_clr_e2", acc_max, 13'h0200);
        send(13'h0000, 13'h0000, EQ, 1'b1, 1'b1, 13'h0000);
        send(13'h1000, 13'h1000, EQ, 1'b0, 1'b1, 13'h1000);
        drain();
        chk("acc_zero_tie", acc_max, 13'h0000);

        // asynchronous reset with both stages full
        out_ready = 1'b0;
        send(13'h0201, 13'h0100, GT, 1'b0, 1'b1, 13'h0201);
        send(13'h0301, 13'h0100, GT, 1'b0, 1'b1, 13'h0301);
        chk("pre_rst_valid", out_valid, 1);
        chk("pre_rst_in_ready", in_ready, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_out_valid", out_valid, 0);
        chk("async_acc_vld", acc_vld, 0);
        chk("async_acc_max", acc_max, 0);
        expq.delete();
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rel_in_ready", in_ready, 1);
        send(13'h1101, 13'h0100, LT, 1'b0, 1'b1, 13'h0100);
        chk("rel_lat_c1", out_valid, 0);
        @(posedge clk); #1;
        chk("rel_lat_c2", out_valid, 1);
        drain();
        chk("rel_acc_max", acc_max, 13'h0100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
